slice_join_router: RTL and testbench

SLICE_JOIN_ROUTER -- requirements
Module: slice_join_router

---
 rtl/slice_join_router.sv | 143 ++++++++++++++
 tb/tb_slice_join_router.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_join_router.sv
// slice_join_router
//   Joins a payload channel and an address channel from the slicer into one
//   packet, queues packets in an in-order FIFO, and presents the FIFO head to
//   four output ports. The port is selected by addr[1:0]. Delivery is strictly
//   in order: a blocked head stalls every packet behind it.
//
// Parameters
//   FIFO_DEPTH  packet FIFO entries (2, 4, 8 or 16)
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   data_in/data_valid/data_ready  7-bit payload channel
//   addr_in/addr_valid/addr_ready  4-bit address channel
//   out_data, out_addr             FIFO head, shared by all output ports
//   out_valid[3:0], out_ready[3:0] one-hot per-port valid, per-port accept
//   fifo_count                     occupied FIFO entries
//   pkt_count                      delivered packets (statistics build only)
//
// Build option
//   SLICE_JOIN_ROUTER_STATS_EN  enables the saturating delivered-packet counter;
//                               when undefined, pkt_count is tied to zero.

module slice_join_router #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [6:0]                  data_in,
  input  logic                        data_valid,
  output logic                        data_ready,
  input  logic [3:0]                  addr_in,
  input  logic                        addr_valid,
  output logic                        addr_ready,
  output logic [6:0]                  out_data,
  output logic [3:0]                  out_addr,
  output logic [3:0]                  out_valid,
  input  logic [3:0]                  out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [15:0]                 pkt_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [6:0]    data_hold_q;
  logic          data_full_q;
  logic [3:0]    addr_hold_q;
  logic          addr_full_q;

  logic [10:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic          data_fire, addr_fire;
  logic [10:0]   head;
  logic [1:0]    head_port;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Push depends only on registered state, so ready never depends on valid.
  assign push       = data_full_q && addr_full_q && !fifo_full;
  assign data_ready = !data_full_q || push;
  assign addr_ready = !addr_full_q || push;
  assign data_fire  = data_valid && data_ready;
  assign addr_fire  = addr_valid && addr_ready;

  assign head       = mem_q[rptr_q];
  assign head_port  = head[8:7];
  assign out_data   = head[6:0];
  assign out_addr   = head[10:7];
  // Only the head's own port can pop it; other ready bits are ignored.
  assign pop        = !fifo_empty && out_ready[head_port];
  assign fifo_count = count_q;

  always_comb begin
    out_valid = 4'b0000;
    if (!fifo_empty) out_valid[head_port] = 1'b1;
  end

  // Hold registers: a same-edge refill wins over the clear from push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_hold_q <= '0;
      data_full_q <= 1'b0;
      addr_hold_q <= '0;
      addr_full_q <= 1'b0;
    end else begin
      if (data_fire) begin
        data_hold_q <= data_in;
        data_full_q <= 1'b1;
      end else if (push) begin
        data_full_q <= 1'b0;
      end
      if (addr_fire) begin
        addr_hold_q <= addr_in;
        addr_full_q <= 1'b1;
      end else if (push) begin
        addr_full_q <= 1'b0;
      end
    end
  end

  // Storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {addr_hold_q, data_hold_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= (wptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + AW'(1);
      if (pop)  rptr_q <= (rptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef SLICE_JOIN_ROUTER_STATS_EN
  logic [15:0] pkt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q <= '0;
    end else if (pop && (pkt_q != 16'hFFFF)) begin
      pkt_q <= pkt_q + 16'd1;
    end
  end

  assign pkt_count = pkt_q;
`else
  assign pkt_count = 16'h0000;
`endif

endmodule

// File: tb/tb_slice_join_router.sv
// Bench for slice_join_router: a queue-based packet model is checked against
// the DUT on every falling edge, and directed scenarios pin the model with
// hand-computed values.

module tb_slice_join_router;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic [6:0]    data_in;
  logic          data_valid;
  logic          data_ready;
  logic [3:0]    addr_in;
  logic          addr_valid;
  logic          addr_ready;
  logic [6:0]    out_data;
  logic [3:0]    out_addr;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [CW-1:0] fifo_count;
  logic [15:0]   pkt_count;

  slice_join_router #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .addr_in    (addr_in),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .pkt_count  (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, need 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: pending halves + packet queue ----------------
  bit          m_dh, m_ah;
  logic [6:0]  m_dv;
  logic [3:0]  m_av;
  logic [10:0] m_q[$];
  logic [10:0] m_log[$];
  int          m_pkt;

  function automatic bit m_push();
    return m_dh && m_ah && (m_q.size() < DEPTH);
  endfunction

  initial begin
    bit psh, dr, ar;
    m_dh = 0; m_ah = 0; m_pkt = 0; m_dv = '0; m_av = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_dh = 0;
        m_ah = 0;
        m_q.delete();
        m_pkt = 0;
      end else begin
        psh = m_push();
        dr  = !m_dh || psh;
        ar  = !m_ah || psh;
        if (m_q.size() > 0 && out_ready[m_q[0][8:7]]) begin
          m_log.push_back(m_q[0]);
          void'(m_q.pop_front());
          if (m_pkt < 65535) m_pkt++;
        end
        if (psh) begin
          m_q.push_back({m_av, m_dv});
          m_dh = 0;
          m_ah = 0;
        end
        if (data_valid && dr) begin
          m_dh = 1;
          m_dv = data_in;
        end
        if (addr_valid && ar) begin
          m_ah = 1;
          m_av = addr_in;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [3:0] ev;
    forever begin
      @(negedge clk);
      ev = 4'b0000;
      if (m_q.size() > 0) ev = 4'b0001 << m_q[0][8:7];
      chk("data_ready", data_ready, !m_dh || m_push());
      chk("addr_ready", addr_ready, !m_ah || m_push());
      chk("out_valid", out_valid, ev);
      chk("fifo_count", fifo_count, m_q.size());
      if (m_q.size() > 0) begin
        chk("out_data", out_data, m_q[0][6:0]);
        chk("out_addr", out_addr, m_q[0][10:7]);
      end
`ifdef SLICE_JOIN_ROUTER_STATS_EN
      chk("pkt_count", pkt_count, m_pkt);
`else
      chk("pkt_count", pkt_count, 0);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_data(input logic [6:0] d);
    bit r;
    int n;
    r = 0; n = 0;
    data_in = d;
    data_valid = 1'b1;
    while (!r && n < 200) begin
      @(negedge clk);
      r = data_ready;
      @(posedge clk);
      #1;
      n++;
    end
    data_valid = 1'b0;
    if (!r) begin
      n_cmp++; n_bad++;
      $display("FAIL send_data_timeout: got no ready, need ready within 200 cycles");
    end
  endtask

  task automatic send_addr(input logic [3:0] a);
    bit r;
    int n;
    r = 0; n = 0;
    addr_in = a;
    addr_valid = 1'b1;
    while (!r && n < 200) begin
      @(negedge clk);
      r = addr_ready;
      @(posedge clk);
      #1;
      n++;
    end
    addr_valid = 1'b0;
    if (!r) begin
      n_cmp++; n_bad++;
      $display("FAIL send_addr_timeout: got no ready, need ready within 200 cycles");
    end
  endtask

  task automatic send_pkt(input logic [6:0] d, input logic [3:0] a);
    fork
      send_data(d);
      send_addr(a);
    join
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, need finish before time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int base;
    rst_n = 1'b0; data_in = '0; data_valid = 0; addr_in = '0; addr_valid = 0;
    out_ready = 4'b0000;
    #1;
    chk("rst_data_ready", data_ready, 1);
    chk("rst_addr_ready", addr_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_pkt_count", pkt_count, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);

    // Single packet: data at cycle 0, address three cycles later.
    out_ready = 4'b1111;
    fork
      send_data(7'h55);
      begin
        cycles(3);
        send_addr(4'hA);
      end
    join
    @(negedge clk);
    chk("single_pre_cnt", fifo_count, 0);
    chk("single_pre_valid", out_valid, 4'b0000);
    @(negedge clk);
    chk("single_valid", out_valid, 4'b0100);
    chk("single_data", out_data, 7'h55);
    chk("single_addr", out_addr, 4'hA);
    chk("single_cnt1", fifo_count, 1);
    @(negedge clk);
    chk("single_cnt0", fifo_count, 0);
    chk("single_log", m_log[m_log.size()-1], {4'hA, 7'h55});
    cycles(1);

    // Full FIFO with outputs stalled, then drain in order.
    out_ready = 4'b0000;
    base = m_log.size();
    for (int i = 0; i < 5; i++) send_pkt(7'(8'h30 + i), 4'(i * 3));
    @(negedge clk);
    chk("full_cnt", fifo_count, 4);
    chk("full_data_ready", data_ready, 0);
    chk("full_addr_ready", addr_ready, 0);
    cycles(1);
    out_ready = 4'b1111;
    cycles(10);
    chk("full_delivered", m_log.size() - base, 5);
    for (int i = 0; i < 5; i++) chk("full_order", m_log[base+i], {4'(i * 3), 7'(8'h30 + i)});

    // Head-of-line blocking: port 1 then port 2, only port 2 ready.
    out_ready = 4'b0100;
    base = m_log.size();
    send_pkt(7'h11, 4'h1);
    send_pkt(7'h22, 4'h6);
    cycles(5);
    chk("hol_cnt", fifo_count, 2);
    chk("hol_valid", out_valid, 4'b0010);
    chk("hol_none", m_log.size() - base, 0);
    out_ready = 4'b0110;
    cycles(3);
    chk("hol_delivered", m_log.size() - base, 2);
    chk("hol_first", m_log[base], {4'h1, 7'h11});
    chk("hol_second", m_log[base+1], {4'h6, 7'h22});

    // Streaming: 20 back-to-back packets, one per cycle after 2-edge latency.
    out_ready = 4'b1111;
    base = m_log.size();
    for (int i = 0; i < 20; i++) send_pkt(7'(i * 5 + 1), 4'(i));
    cycles(2);
    chk("stream_delivered", m_log.size() - base, 20);
    for (int i = 0; i < 20; i++) chk("stream_order", m_log[base+i], {4'(i), 7'(i * 5 + 1)});

    // Reset with three packets queued.
    out_ready = 4'b0000;
    for (int i = 0; i < 3; i++) send_pkt(7'(8'h40 + i), 4'(i));
    cycles(3);
    chk("rstq_cnt", fifo_count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstq_valid", out_valid, 0);
    chk("rstq_fifo", fifo_count, 0);
    chk("rstq_data_ready", data_ready, 1);
    chk("rstq_addr_ready", addr_ready, 1);
    chk("rstq_pkt", pkt_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = m_log.size();
    out_ready = 4'b1111;
    cycles(6);
    chk("rstq_lost", m_log.size() - base, 0);
    chk("rstq_fifo_after", fifo_count, 0);

    // Statistics: ten deliveries after reset.
    for (int i = 0; i < 10; i++) send_pkt(7'(8'h60 + i), 4'(15 - i));
    cycles(3);
`ifdef SLICE_JOIN_ROUTER_STATS_EN
    chk("stats_pkt", pkt_count, 10);
`else
    chk("stats_pkt", pkt_count, 0);
`endif
    chk("stats_fifo", fifo_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
